// File: rtl/rocketcpu_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rocketcpu_bus_scheduler
// Description : Three-master Wishbone scheduler (ibus, dbus, DMA) sharing the
//               SoC memory bus. Round-robin arbitration with the grant locked
//               for a whole cycle, plus a watchdog that force-completes cycles
//               no slave acknowledges and records the faulting address.
// Revision    : 1.0 - initial release
// ============================================================================
module rocketcpu_bus_scheduler #(
  parameter int TIMEOUT = 64
) (
  input  logic        i_wb_clk,
  input  logic        i_rst_n,
  // master 0: CPU instruction bus (read-only)
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  // master 1: CPU data bus
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  // master 2: DMA
  input  logic [31:0] i_dma_adr,
  input  logic [31:0] i_dma_dat,
  input  logic [3:0]  i_dma_sel,
  input  logic        i_dma_we,
  input  logic        i_dma_cyc,
  output logic [31:0] o_dma_rdt,
  output logic        o_dma_ack,
  // slave side
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  // watchdog reporting
  output logic        o_err,
  output logic [31:0] o_err_adr,
  output logic [1:0]  o_err_master,
  input  logic        i_err_clr
);

  localparam logic [0:0] c_IDLE     = 1'b0;
  localparam logic [0:0] c_BUSY     = 1'b1;
  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic [1:0]  r_grant;
  logic [1:0]  r_last;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic [31:0] r_err_adr;
  logic [1:0]  r_err_master;

  logic [2:0]  w_req;
  logic [1:0]  w_pick;
  logic        w_busy;
  logic        w_gnt_cyc;
  logic [31:0] w_gnt_adr;
  logic        w_timeout;
  logic        w_ack_any;

  assign w_req  = {i_dma_cyc, i_dbus_cyc, i_ibus_cyc};
  assign w_busy = (r_state == c_BUSY);

  // Round-robin pick: first requester searching from last+1 (mod 3)
  always_comb begin
    w_pick = 2'd0;
    case (r_last)
      2'd0: begin
        if (w_req[1])      w_pick = 2'd1;
        else if (w_req[2]) w_pick = 2'd2;
        else               w_pick = 2'd0;
      end
      2'd1: begin
        if (w_req[2])      w_pick = 2'd2;
        else if (w_req[0]) w_pick = 2'd0;
        else               w_pick = 2'd1;
      end
      default: begin
        if (w_req[0])      w_pick = 2'd0;
        else if (w_req[1]) w_pick = 2'd1;
        else               w_pick = 2'd2;
      end
    endcase
  end

  // Request and address of the currently granted master
  always_comb begin
    w_gnt_cyc = 1'b0;
    w_gnt_adr = 32'd0;
    case (r_grant)
      2'd0: begin
        w_gnt_cyc = i_ibus_cyc;
        w_gnt_adr = i_ibus_adr;
      end
      2'd1: begin
        w_gnt_cyc = i_dbus_cyc;
        w_gnt_adr = i_dbus_adr;
      end
      default: begin
        w_gnt_cyc = i_dma_cyc;
        w_gnt_adr = i_dma_adr;
      end
    endcase
  end

  // Watchdog fires only when the master still holds cyc; a real ack wins
  assign w_timeout = w_busy & w_gnt_cyc & ~i_wb_ack & (r_cnt == c_TMO_LAST);
  assign w_ack_any = w_busy & (i_wb_ack | w_timeout);

  // State register
  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= c_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: leave BUSY on ack, abort or watchdog expiry
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: if (|w_req) w_state_nxt = c_BUSY;
      default: begin
        if (i_wb_ack || !w_gnt_cyc || w_timeout) w_state_nxt = c_IDLE;
      end
    endcase
  end

  // Outputs: slave-side mux follows the grant, responses steered back
  always_comb begin
    o_wb_adr   = 32'd0;
    o_wb_dat   = 32'd0;
    o_wb_sel   = 4'd0;
    o_wb_we    = 1'b0;
    o_wb_cyc   = 1'b0;
    o_ibus_ack = 1'b0;
    o_dbus_ack = 1'b0;
    o_dma_ack  = 1'b0;
    if (w_busy) begin
      o_wb_cyc = w_gnt_cyc & ~w_timeout;
      case (r_grant)
        2'd0: begin
          o_wb_adr   = i_ibus_adr;
          o_wb_sel   = 4'hF;
          o_ibus_ack = w_ack_any;
        end
        2'd1: begin
          o_wb_adr   = i_dbus_adr;
          o_wb_dat   = i_dbus_dat;
          o_wb_sel   = i_dbus_sel;
          o_wb_we    = i_dbus_we;
          o_dbus_ack = w_ack_any;
        end
        default: begin
          o_wb_adr  = i_dma_adr;
          o_wb_dat  = i_dma_dat;
          o_wb_sel  = i_dma_sel;
          o_wb_we   = i_dma_we;
          o_dma_ack = w_ack_any;
        end
      endcase
    end
  end

  // Read data is broadcast; a watchdog completion returns all-ones
  assign o_ibus_rdt = w_timeout ? 32'hFFFF_FFFF : i_wb_rdt;
  assign o_dbus_rdt = w_timeout ? 32'hFFFF_FFFF : i_wb_rdt;
  assign o_dma_rdt  = w_timeout ? 32'hFFFF_FFFF : i_wb_rdt;

  // Grant, round-robin pointer and watchdog counter
  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant <= 2'd0;
      r_last  <= 2'd2;
      r_cnt   <= 8'd0;
    end else if (!w_busy) begin
      r_cnt <= 8'd0;
      if (|w_req) begin
        r_grant <= w_pick;
        r_last  <= w_pick;
      end
    end else if (!i_wb_ack) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Sticky error flag and fault capture; a new timeout beats a clear
  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err        <= 1'b0;
      r_err_adr    <= 32'd0;
      r_err_master <= 2'd0;
    end else if (w_timeout) begin
      r_err        <= 1'b1;
      r_err_adr    <= w_gnt_adr;
      r_err_master <= r_grant;
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign o_err        = r_err;
  assign o_err_adr    = r_err_adr;
  assign o_err_master = r_err_master;

endmodule
`default_nettype wire

// File: tb/tb_rocketcpu_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rocketcpu_bus_scheduler
// Description : Directed self-checking bench for rocketcpu_bus_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rocketcpu_bus_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ibus_adr;
  logic        ibus_cyc;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic [31:0] dbus_adr, dbus_dat;
  logic [3:0]  dbus_sel;
  logic        dbus_we, dbus_cyc;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  logic [31:0] dma_adr, dma_dat;
  logic [3:0]  dma_sel;
  logic        dma_we, dma_cyc;
  logic [31:0] dma_rdt;
  logic        dma_ack;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        err;
  logic [31:0] err_adr;
  logic [1:0]  err_master;
  logic        err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  rocketcpu_bus_scheduler #(.TIMEOUT(64)) dut (
    .i_wb_clk(clk), .i_rst_n(rst_n),
    .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc),
    .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
    .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel),
    .i_dbus_we(dbus_we), .i_dbus_cyc(dbus_cyc),
    .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack),
    .i_dma_adr(dma_adr), .i_dma_dat(dma_dat), .i_dma_sel(dma_sel),
    .i_dma_we(dma_we), .i_dma_cyc(dma_cyc),
    .o_dma_rdt(dma_rdt), .o_dma_ack(dma_ack),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel),
    .o_wb_we(wb_we), .o_wb_cyc(wb_cyc),
    .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack),
    .o_err(err), .o_err_adr(err_adr), .o_err_master(err_master),
    .i_err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] acks();
    return {29'd0, dma_ack, dbus_ack, ibus_ack};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hung expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] e_adr [3];
    logic [31:0] e_dat [3];
    logic [31:0] e_we  [3];

    rst_n = 1'b0;
    ibus_adr = 0; ibus_cyc = 0;
    dbus_adr = 0; dbus_dat = 0; dbus_sel = 0; dbus_we = 0; dbus_cyc = 0;
    dma_adr = 0; dma_dat = 0; dma_sel = 0; dma_we = 0; dma_cyc = 0;
    wb_rdt = 0; wb_ack = 0; err_clr = 0;

    // ---------------- reset state ----------------
    #12;
    chk("rst_wb_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("rst_acks", acks(), 32'd0);
    chk("rst_wb_adr", wb_adr, 32'd0);
    chk("rst_wb_sel", {28'd0, wb_sel}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_adr", err_adr, 32'd0);
    chk("rst_err_master", {30'd0, err_master}, 32'd0);
    rst_n = 1'b1;

    // ---------------- single master ibus read ----------------
    tick();
    ibus_adr = 32'h0010_0000; ibus_cyc = 1'b1;
    tick(); // BUSY cycle 1
    chk("single_cyc", {31'd0, wb_cyc}, 32'd1);
    chk("single_adr", wb_adr, 32'h0010_0000);
    chk("single_sel", {28'd0, wb_sel}, 32'hF);
    chk("single_we", {31'd0, wb_we}, 32'd0);
    chk("single_noack_c1", acks(), 32'd0);
    tick(); // cycle 2
    tick(); // cycle 3
    wb_ack = 1'b1; wb_rdt = 32'hDEAD_BEEF;
    #1;
    chk("single_acks", acks(), 32'd1);
    chk("single_rdt", ibus_rdt, 32'hDEAD_BEEF);
    tick(); // IDLE
    wb_ack = 1'b0; ibus_cyc = 1'b0;
    #1;
    chk("single_idle_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("single_idle_acks", acks(), 32'd0);

    // ---------------- contention from reset ----------------
    rst_n = 1'b0;
    #1;
    ibus_adr = 32'h0000_0100; ibus_cyc = 1'b1;
    dbus_adr = 32'h0000_0200; dbus_dat = 32'h1111_1111; dbus_sel = 4'h3;
    dbus_we = 1'b1; dbus_cyc = 1'b1;
    dma_adr = 32'h0000_0300; dma_dat = 32'h2222_2222; dma_sel = 4'hC;
    dma_we = 1'b0; dma_cyc = 1'b1;
    e_adr[0] = 32'h0000_0100; e_dat[0] = 32'd0;          e_we[0] = 32'd0;
    e_adr[1] = 32'h0000_0200; e_dat[1] = 32'h1111_1111; e_we[1] = 32'd1;
    e_adr[2] = 32'h0000_0300; e_dat[2] = 32'h2222_2222; e_we[2] = 32'd0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); // BUSY
      chk("rr_adr", wb_adr, e_adr[i % 3]);
      chk("rr_dat", wb_dat, e_dat[i % 3]);
      chk("rr_we", {31'd0, wb_we}, e_we[i % 3]);
      wb_ack = 1'b1; wb_rdt = 32'hA5A5_0000 + i;
      #1;
      chk("rr_acks", acks(), 32'd1 << (i % 3));
      tick(); // IDLE
      wb_ack = 1'b0;
      if (i == 5) begin
        ibus_cyc = 1'b0; dbus_cyc = 1'b0; dma_cyc = 1'b0;
      end
      #1;
      chk("rr_idle_cyc", {31'd0, wb_cyc}, 32'd0);
    end

    // ---------------- timeout on dbus write ----------------
    dbus_adr = 32'h0300_0000; dbus_we = 1'b1; dbus_cyc = 1'b1;
    tick(); // BUSY cycle 1
    repeat (62) tick(); // cycle 63
    chk("tmo_c63_cyc", {31'd0, wb_cyc}, 32'd1);
    chk("tmo_c63_acks", acks(), 32'd0);
    tick(); // cycle 64
    chk("tmo_c64_acks", acks(), 32'd2);
    chk("tmo_c64_rdt", dbus_rdt, 32'hFFFF_FFFF);
    chk("tmo_c64_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("tmo_c64_err", {31'd0, err}, 32'd0);
    tick(); // IDLE
    dbus_cyc = 1'b0;
    #1;
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_err_adr", err_adr, 32'h0300_0000);
    chk("tmo_err_master", {30'd0, err_master}, 32'd1);
    chk("tmo_idle_acks", acks(), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", {31'd0, err}, 32'd0);
    chk("clr_err_adr_hold", err_adr, 32'h0300_0000);

    // ---------------- ack on the timeout boundary ----------------
    ibus_adr = 32'h0400_0000; ibus_cyc = 1'b1;
    tick(); // BUSY cycle 1 (last=1, ibus wins over none else)
    repeat (63) tick(); // cycle 64
    wb_ack = 1'b1; wb_rdt = 32'h1234_5678;
    #1;
    chk("bnd_acks", acks(), 32'd1);
    chk("bnd_rdt", ibus_rdt, 32'h1234_5678);
    chk("bnd_cyc", {31'd0, wb_cyc}, 32'd1);
    tick(); // IDLE
    wb_ack = 1'b0; ibus_cyc = 1'b0;
    #1;
    chk("bnd_err", {31'd0, err}, 32'd0);
    chk("bnd_err_master_hold", {30'd0, err_master}, 32'd1);

    // ---------------- DMA abort ----------------
    dma_adr = 32'h0000_0500; dma_cyc = 1'b1;
    tick(); // BUSY cycle 1, grant DMA
    chk("abort_adr", wb_adr, 32'h0000_0500);
    tick(); // cycle 2
    dma_cyc = 1'b0;
    ibus_adr = 32'h0000_0600; ibus_cyc = 1'b1;
    dbus_adr = 32'h0000_0700; dbus_cyc = 1'b1;
    #1;
    chk("abort_cyc_low", {31'd0, wb_cyc}, 32'd0);
    chk("abort_acks", acks(), 32'd0);
    tick(); // IDLE
    chk("abort_idle_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("abort_idle_acks", acks(), 32'd0);
    tick(); // next grant
    chk("abort_next_adr", wb_adr, 32'h0000_0600);

    // ---------------- async reset mid-BUSY ----------------
    wb_ack = 1'b1;
    #1;
    chk("arst_pre_ack", acks(), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("arst_acks", acks(), 32'd0);
    chk("arst_err_adr", err_adr, 32'd0);
    wb_ack = 1'b0;
    #1;
    rst_n = 1'b1;
    tick(); // first grant after reset
    chk("arst_first_adr", wb_adr, 32'h0000_0600);
    chk("arst_first_cyc", {31'd0, wb_cyc}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rocketcpu_bus_scheduler.md
# rocketcpu_bus_scheduler

Three-master Wishbone scheduler for the SoC memory bus. It shares the single memory-side bus (flash, RAM, UART, audio registers, GPIO, timer, codec SPI) between the SERV instruction bus, the SERV data bus and a DMA master. Arbitration is round-robin, and each grant is locked for the whole cycle. A watchdog completes any cycle that no slave acknowledges, for example an unmapped address, so the CPU never hangs. It records the faulting address.

## Interface
- TIMEOUT, default 64: cycles in BUSY without `i_wb_ack` before the scheduler force-terminates the cycle; legal range 2..255.
- i_wb_clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_ibus_adr  in  32  master 0 (CPU ibus) address; read-only master.
- i_ibus_cyc  in  1  master 0 request.
- o_ibus_rdt  out  32  master 0 read data.
- o_ibus_ack  out  1  master 0 acknowledge.
- i_dbus_adr / i_dbus_dat / i_dbus_sel / i_dbus_we / i_dbus_cyc  in  32/32/4/1/1  master 1 (CPU dbus).
- o_dbus_rdt / o_dbus_ack  out  32/1  master 1 response.
- i_dma_adr / i_dma_dat / i_dma_sel / i_dma_we / i_dma_cyc  in  32/32/4/1/1  master 2 (DMA).
- o_dma_rdt / o_dma_ack  out  32/1  master 2 response.
- o_wb_adr / o_wb_dat / o_wb_sel / o_wb_we / o_wb_cyc  out  32/32/4/1/1  slave-side bus toward the address decoder.
- i_wb_rdt / i_wb_ack  in  32/1  slave-side response, already muxed by the decoder.
- o_err  out  1  sticky timeout flag.
- o_err_adr  out  32  address of the most recent timed-out cycle.
- o_err_master  out  2  index of the master that timed out.
- i_err_clr  in  1  clears `o_err`; the address and master registers hold their values.

## Operation
- States: IDLE and BUSY.
- IDLE: if any `*_cyc` is high, grant the first requester found searching round-robin from `last+1` (mod 3), where `last` is the index of the last granted master. Register the grant and `last`, then enter BUSY. If no request is present, stay in IDLE.
- BUSY: the slave-side outputs follow the granted master combinationally. Master 0 drives `we=0`, `sel=4'hF`, `dat=0`. `o_wb_cyc` equals the granted master's cyc, except that it is forced low on a timeout cycle.
- Responses:
  - `i_wb_rdt` is broadcast to all three `*_rdt` outputs.
  - Only the granted master's ack may be high, and it equals `i_wb_ack`.
  - Non-granted acks are 0.
- BUSY exits to IDLE on any of:
  - `i_wb_ack` high;
  - the granted master drops cyc (abort, no ack issued);
  - timeout.
- Watchdog:
  - The counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When count == TIMEOUT-1 and `i_wb_ack` is low, the scheduler asserts the granted master's ack for one cycle and forces `*_rdt` to 32'hFFFF_FFFF.
  - On the next edge it sets `o_err`, captures `o_err_adr` and `o_err_master`, and returns to IDLE.
- If a slave ack and the timeout fall in the same cycle, the ack wins: normal completion, `o_err` is not set.
- If `i_err_clr` and a new timeout fall in the same edge, the set wins.
- Reset mid-cycle: the block returns to IDLE immediately. The slave-side `cyc` and all acks drop asynchronously, and the in-flight transfer is discarded.

## Timing
- Reset values:
  - state IDLE, grant none, `last` = 2 (so master 0 wins first);
  - all `*_ack` = 0, `o_wb_cyc` = 0, `o_wb_adr/dat/sel/we` = 0;
  - `o_err` = 0, `o_err_adr` = 0, `o_err_master` = 0;
  - counter = 0.
- Grant latency: a request sampled in IDLE at edge N gives `o_wb_cyc` high from edge N through the completing cycle.
- Ack passes combinationally: zero added latency on the response path.
- There is exactly one IDLE cycle between consecutive transactions, which gives the masters a cycle to drop cyc after ack.
- A cycle ending by timeout holds `o_wb_cyc` high for TIMEOUT-1 cycles. The forced ack appears in the TIMEOUT-th BUSY cycle.
- Round-robin fairness: with all three masters requesting continuously, grants cycle 0,1,2,0,... and each master waits at most two transactions.

## Test plan
- Single master: ibus reads 0x0010_0000, slave acks after 3 cycles with 0xDEADBEEF. Expect `o_ibus_ack` one cycle, `o_ibus_rdt`=0xDEADBEEF, the other acks 0, and IDLE for one cycle afterwards.
- Contention: all three cyc high from reset, every slave acks after 1 cycle. Expect grant order 0,1,2,0,1,2, `o_wb_we` and `o_wb_dat` tracking the granted master, and no overlapping acks.
- Timeout: dbus writes 0x0300_0000, no slave ack. Expect `o_dbus_ack` in BUSY cycle 64 with rdt 0xFFFF_FFFF, then `o_err`=1, `o_err_adr`=0x0300_0000, `o_err_master`=1. Pulse `i_err_clr` and expect `o_err`=0.
- Ack on the timeout boundary: slave ack exactly in BUSY cycle 64. Expect normal rdt, `o_err` stays 0.
- Abort: DMA drops cyc in cycle 2 of BUSY with no ack. Expect return to IDLE, `o_wb_cyc` low, no ack to any master, and the next grant going to master 0.
- Async reset: assert `i_rst_n` low mid-BUSY between clock edges. Expect `o_wb_cyc` and all acks 0 immediately; after release, the first grant goes to master 0.
